// File: rtl/riscv_trace_fifo.sv
// riscv_trace_fifo
//   Commit-trace buffer for the riscv core. Register writebacks and data-memory
//   writes are queued as {kind, tag, data} records in a first-word-fall-through
//   FIFO and drained over a valid/ready handshake. After Halt, capture stops, the
//   FIFO drains and done is raised.
// Ports
//   clk, reset                     : clock, synchronous active-low reset
//   reg_write_sig, reg_num, reg_data : register writeback event (x0 filtered)
//   wr, addr, wr_data              : data-memory write event
//   Halt                           : core halt level
//   out_valid, out_ready           : drain handshake
//   out_kind, out_tag, out_data    : head record (zero when out_valid is low)
//   level                          : occupancy 0..DEPTH
//   overflow, drop_count           : sticky drop flag, saturating drop counter
//   done                           : halted and fully drained
module riscv_trace_fifo #(
   parameter int unsigned DEPTH  = 16,
   parameter int unsigned DATA_W = 32
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       reg_write_sig,
   input  logic [4:0]                 reg_num,
   input  logic [DATA_W-1:0]          reg_data,
   input  logic                       wr,
   input  logic [8:0]                 addr,
   input  logic [DATA_W-1:0]          wr_data,
   input  logic                       Halt,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic                       out_kind,
   output logic [8:0]                 out_tag,
   output logic [DATA_W-1:0]          out_data,
   output logic [$clog2(DEPTH):0]     level,
   output logic                       overflow,
   output logic [15:0]                drop_count,
   output logic                       done
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned LW = PW + 1;
   localparam int unsigned RW = DATA_W + 10;

   typedef enum logic [1:0] {StRun, StDrain, StDone} state_e;

   state_e           state_q, state_d;
   logic [PW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d, wptr_mem;
   logic [LW-1:0]    level_q, level_d, free_slots, mem_need;
   logic             overflow_q, overflow_d;
   logic [15:0]      drop_q, drop_d;
   logic [16:0]      drop_sum;
   logic [RW-1:0]    mem_q [DEPTH];
   logic [RW-1:0]    head;

   logic             pop, capture, reg_ev, mem_ev, push_reg, push_mem;
   logic [1:0]       n_push, n_drop;

   // ---------------------------------------------------------------------------
   // Push / pop decision
   // ---------------------------------------------------------------------------
   always_comb begin
      pop        = (level_q != '0) && out_ready;
      capture    = (state_q == StRun);
      reg_ev     = capture && reg_write_sig && (reg_num != 5'd0);
      mem_ev     = capture && wr;
      // A pop in this cycle frees its slot for a push in the same cycle.
      free_slots = LW'(DEPTH) - level_q + LW'(pop);
      push_reg   = reg_ev && (free_slots != '0);
      // Register record has priority; the memory record needs a slot after it.
      mem_need   = reg_ev ? LW'(2) : LW'(1);
      push_mem   = mem_ev && (free_slots >= mem_need);
      n_push     = {1'b0, push_reg} + {1'b0, push_mem};
      n_drop     = {1'b0, reg_ev & ~push_reg} + {1'b0, mem_ev & ~push_mem};

      level_d    = level_q + LW'(n_push) - LW'(pop);
      wptr_d     = wptr_q + PW'(n_push);
      rptr_d     = rptr_q + PW'(pop);
      wptr_mem   = wptr_q + PW'(push_reg);

      drop_sum   = {1'b0, drop_q} + 17'(n_drop);
      drop_d     = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      overflow_d = overflow_q | (n_drop != 2'd0);
   end

   // ---------------------------------------------------------------------------
   // FIFO state
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!reset) begin
         wptr_q     <= '0;
         rptr_q     <= '0;
         level_q    <= '0;
         overflow_q <= 1'b0;
         drop_q     <= '0;
      end else begin
         wptr_q     <= wptr_d;
         rptr_q     <= rptr_d;
         level_q    <= level_d;
         overflow_q <= overflow_d;
         drop_q     <= drop_d;
      end
   end

   // Storage needs no reset; occupancy alone decides what is valid.
   always_ff @(posedge clk) begin
      if (push_reg) begin
         mem_q[wptr_q] <= {1'b0, 4'b0000, reg_num, reg_data};
      end
      if (push_mem) begin
         mem_q[wptr_mem] <= {1'b1, addr, wr_data};
      end
   end

   // ---------------------------------------------------------------------------
   // Capture state machine
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= StRun;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StRun:   if (Halt) state_d = StDrain;
         StDrain: if (level_d == '0) state_d = StDone;
         StDone:  state_d = StDone;
         default: state_d = StRun;
      endcase
   end

   always_comb begin
      done = (state_q == StDone);
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   always_comb begin
      head       = mem_q[rptr_q];
      out_valid  = (level_q != '0);
      out_kind   = out_valid ? head[RW-1] : 1'b0;
      out_tag    = out_valid ? head[RW-2:DATA_W] : 9'd0;
      out_data   = out_valid ? head[DATA_W-1:0] : '0;
      level      = level_q;
      overflow   = overflow_q;
      drop_count = drop_q;
   end

endmodule

// File: tb/tb_riscv_trace_fifo.sv
module tb_riscv_trace_fifo;

   localparam int DEPTH  = 16;
   localparam int DATA_W = 32;

   logic              clk;
   logic              reset;
   logic              reg_write_sig;
   logic [4:0]        reg_num;
   logic [31:0]       reg_data;
   logic              wr;
   logic [8:0]        addr;
   logic [31:0]       wr_data;
   logic              Halt;
   logic              out_valid;
   logic              out_ready;
   logic              out_kind;
   logic [8:0]        out_tag;
   logic [31:0]       out_data;
   logic [4:0]        level;
   logic              overflow;
   logic [15:0]       drop_count;
   logic              done;

   int errors = 0;
   int checks = 0;

   // Reference model: a queue of {kind, tag, data} records plus phase and drop state.
   logic [41:0] mq[$];
   int          m_st;     // 0 run, 1 drain, 2 done
   int          m_drop;
   bit          m_ovf;

   riscv_trace_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
      .clk           (clk),
      .reset         (reset),
      .reg_write_sig (reg_write_sig),
      .reg_num       (reg_num),
      .reg_data      (reg_data),
      .wr            (wr),
      .addr          (addr),
      .wr_data       (wr_data),
      .Halt          (Halt),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_kind      (out_kind),
      .out_tag       (out_tag),
      .out_data      (out_data),
      .level         (level),
      .overflow      (overflow),
      .drop_count    (drop_count),
      .done          (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic m_drop_one();
      m_ovf = 1'b1;
      if (m_drop < 65535) m_drop++;
   endtask

   // Advance the model by one clock edge using the inputs currently applied.
   task automatic model_step();
      int fr;
      if (!reset) begin
         mq.delete();
         m_st = 0;
         m_drop = 0;
         m_ovf = 1'b0;
         return;
      end
      if (mq.size() > 0 && out_ready) void'(mq.pop_front());
      if (m_st == 0) begin
         fr = DEPTH - mq.size();
         if (reg_write_sig && reg_num != 5'd0) begin
            if (fr > 0) begin
               mq.push_back({1'b0, 4'b0000, reg_num, reg_data});
               fr--;
            end else m_drop_one();
         end
         if (wr) begin
            if (fr > 0) mq.push_back({1'b1, addr, wr_data});
            else m_drop_one();
         end
         if (Halt) m_st = 1;
      end else if (m_st == 1 && mq.size() == 0) begin
         m_st = 2;
      end
   endtask

   function automatic logic [65:0] model_vec();
      logic [41:0] h;
      h = (mq.size() > 0) ? mq[0] : 42'd0;
      return {mq.size() > 0, h, 5'(mq.size()), m_ovf, 16'(m_drop), m_st == 2};
   endfunction

   task automatic cycle();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_in();
      reg_write_sig = 1'b0;
      reg_num       = 5'd0;
      reg_data      = 32'd0;
      wr            = 1'b0;
      addr          = 9'd0;
      wr_data       = 32'd0;
      Halt          = 1'b0;
   endtask

   task automatic do_reset();
      clear_in();
      out_ready = 1'b0;
      reset = 1'b0;
      cycle();
      reset = 1'b1;
   endtask

   task automatic test_reset();
      clear_in();
      reset = 1'b0;
      out_ready = 1'b1;
      reg_write_sig = 1'b1;   // events during reset must not be captured
      reg_num = 5'd3;
      wr = 1'b1;
      cycle();
      reset = 1'b1;
      clear_in();
      checks++;
      if ({out_valid, level} !== 6'd0) begin
         errors++;
         $display("FAIL reset_level: valid=%0b level=%0d, want 0/0", out_valid, level);
      end
      checks++;
      if ({out_kind, out_tag, out_data} !== 42'd0) begin
         errors++;
         $display("FAIL reset_head: kind=%0b tag=%h data=%h, want 0", out_kind, out_tag, out_data);
      end
      checks++;
      if ({overflow, drop_count, done} !== 18'd0) begin
         errors++;
         $display("FAIL reset_flags: ovf=%0b drops=%0d done=%0b, want 0", overflow, drop_count,
                  done);
      end
   endtask

   task automatic test_basic();
      do_reset();
      out_ready = 1'b1;
      reg_write_sig = 1'b1;
      reg_num = 5'd5;
      reg_data = 32'h12345678;
      cycle();
      clear_in();
      checks++;
      if ({out_valid, out_kind, out_tag, out_data} !== {1'b1, 1'b0, 9'h005, 32'h12345678}) begin
         errors++;
         $display("FAIL basic_reg: valid=%0b kind=%0b tag=%h data=%h, want 1/0/005/12345678",
                  out_valid, out_kind, out_tag, out_data);
      end
      wr = 1'b1;
      addr = 9'h040;
      wr_data = 32'hDEADBEEF;
      cycle();
      clear_in();
      checks++;
      if ({out_valid, out_kind, out_tag, out_data, level} !==
          {1'b1, 1'b1, 9'h040, 32'hDEADBEEF, 5'd1}) begin
         errors++;
         $display("FAIL basic_mem: valid=%0b kind=%0b tag=%h data=%h level=%0d, want 1/1/040/deadbeef/1",
                  out_valid, out_kind, out_tag, out_data, level);
      end
      cycle();
      checks++;
      if ({out_valid, level} !== 6'd0) begin
         errors++;
         $display("FAIL basic_empty: valid=%0b level=%0d, want 0/0", out_valid, level);
      end
   endtask

   task automatic test_x0_filter();
      do_reset();
      for (int i = 0; i < 10; i++) begin
         reg_write_sig = 1'b1;
         reg_num = 5'd0;
         reg_data = $urandom;
         out_ready = 1'($urandom);
         cycle();
         checks++;
         if ({out_valid, level, drop_count} !== 22'd0) begin
            errors++;
            $display("FAIL x0_filter[%0d]: valid=%0b level=%0d drops=%0d, want 0", i, out_valid,
                     level, drop_count);
         end
      end
      clear_in();
   endtask

   task automatic test_overflow();
      do_reset();
      for (int i = 0; i < DEPTH + 3; i++) begin
         reg_write_sig = 1'b1;
         reg_num = 5'(i % 31 + 1);
         reg_data = 32'(i);
         cycle();
      end
      clear_in();
      checks++;
      if ({level, overflow, drop_count} !== {5'd16, 1'b1, 16'd3}) begin
         errors++;
         $display("FAIL overflow_state: level=%0d ovf=%0b drops=%0d, want 16/1/3", level, overflow,
                  drop_count);
      end
      out_ready = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         checks++;
         if ({out_valid, out_kind, out_tag, out_data} !==
             {1'b1, 1'b0, 9'(i % 31 + 1), 32'(i)}) begin
            errors++;
            $display("FAIL overflow_drain[%0d]: valid=%0b tag=%h data=%h, want tag %h data %h", i,
                     out_valid, out_tag, out_data, 9'(i % 31 + 1), i);
         end
         cycle();
      end
      checks++;
      if (level !== 5'd0) begin
         errors++;
         $display("FAIL overflow_empty: level=%0d, want 0", level);
      end
   endtask

   task automatic test_dual_at_15();
      do_reset();
      for (int i = 0; i < DEPTH - 1; i++) begin
         reg_write_sig = 1'b1;
         reg_num = 5'd3;
         reg_data = 32'(i);
         cycle();
      end
      reg_write_sig = 1'b1;
      reg_num = 5'd1;
      reg_data = 32'd1;
      wr = 1'b1;
      addr = 9'h004;
      wr_data = 32'd2;
      cycle();
      clear_in();
      checks++;
      if ({level, drop_count} !== {5'd16, 16'd1}) begin
         errors++;
         $display("FAIL dual_nopop: level=%0d drops=%0d, want 16/1", level, drop_count);
      end
      out_ready = 1'b1;
      cycle();
      reg_write_sig = 1'b1;
      reg_num = 5'd1;
      reg_data = 32'd1;
      wr = 1'b1;
      addr = 9'h004;
      wr_data = 32'd2;
      cycle();
      clear_in();
      out_ready = 1'b0;
      checks++;
      if ({level, drop_count} !== {5'd16, 16'd1} || model_vec() !== {out_valid, out_kind, out_tag,
          out_data, level, overflow, drop_count, done}) begin
         errors++;
         $display("FAIL dual_pop: level=%0d drops=%0d, want 16/1", level, drop_count);
      end
   endtask

   task automatic test_halt_drain();
      int pops;
      bit seen_done;
      do_reset();
      for (int i = 0; i < 5; i++) begin
         wr = 1'b1;
         addr = 9'(i);
         wr_data = 32'(100 + i);
         Halt = (i == 4);
         cycle();
      end
      pops = 0;
      seen_done = 1'b0;
      out_ready = 1'b1;
      for (int c = 0; c < 20 && !seen_done; c++) begin
         reg_write_sig = 1'($urandom);
         reg_num = 5'($urandom_range(1, 31));
         reg_data = $urandom;
         wr = 1'($urandom);
         addr = 9'($urandom);
         wr_data = $urandom;
         Halt = 1'($urandom);
         if (out_valid && out_ready) begin
            checks++;
            if (out_data !== 32'(100 + pops)) begin
               errors++;
               $display("FAIL halt_record[%0d]: data=%0d, want %0d", pops, out_data, 100 + pops);
            end
            pops++;
         end
         cycle();
         checks++;
         if (done !== (pops == 5)) begin
            errors++;
            $display("FAIL halt_done_timing: done=%0b after %0d pops, want %0b", done, pops,
                     pops == 5);
         end
         seen_done = done;
      end
      checks++;
      if (pops !== 5 || !seen_done || level !== 5'd0) begin
         errors++;
         $display("FAIL halt_drain: pops=%0d done=%0b level=%0d, want 5/1/0", pops, seen_done,
                  level);
      end
      clear_in();
   endtask

   task automatic test_reset_mid();
      do_reset();
      for (int i = 0; i < 8; i++) begin
         wr = 1'b1;
         addr = 9'(i);
         wr_data = 32'(i);
         cycle();
      end
      clear_in();
      Halt = 1'b1;
      cycle();
      Halt = 1'b0;
      reset = 1'b0;
      reg_write_sig = 1'b1;
      reg_num = 5'd9;
      cycle();
      reset = 1'b1;
      clear_in();
      checks++;
      if ({level, out_valid, done, overflow} !== 8'd0) begin
         errors++;
         $display("FAIL reset_mid: level=%0d valid=%0b done=%0b ovf=%0b, want 0", level,
                  out_valid, done, overflow);
      end
      reg_write_sig = 1'b1;
      reg_num = 5'd2;
      reg_data = 32'd7;
      cycle();
      clear_in();
      checks++;
      if ({out_valid, out_kind, out_tag, out_data} !== {1'b1, 1'b0, 9'd2, 32'd7}) begin
         errors++;
         $display("FAIL reset_mid_capture: valid=%0b tag=%h data=%h, want 1/002/7", out_valid,
                  out_tag, out_data);
      end
   endtask

   task automatic test_random();
      logic [65:0] got;
      logic [65:0] exp;
      do_reset();
      for (int i = 0; i < 800; i++) begin
         reset = ($urandom_range(0, 99) != 0);
         reg_write_sig = 1'($urandom);
         reg_num = 5'($urandom);
         reg_data = $urandom;
         wr = 1'($urandom);
         addr = 9'($urandom);
         wr_data = $urandom;
         Halt = ($urandom_range(0, 79) == 0);
         out_ready = ($urandom_range(0, 3) < (((i / 100) % 2) != 0 ? 3 : 1));
         cycle();
         got = {out_valid, out_kind, out_tag, out_data, level, overflow, drop_count, done};
         exp = model_vec();
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL random[%0d]: got=%h want=%h", i, got, exp);
         end
      end
      reset = 1'b1;
      clear_in();
   endtask

   initial begin
      m_st = 0;
      m_drop = 0;
      m_ovf = 1'b0;
      reset = 1'b0;
      out_ready = 1'b0;
      clear_in();
      test_reset();
      test_basic();
      test_x0_filter();
      test_overflow();
      test_dual_at_15();
      test_halt_drain();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/riscv_trace_fifo.md
# riscv_trace_fifo

Commit-trace buffer downstream of the `riscv` core. It captures two kinds of event: register writebacks (`reg_write_sig`, `reg_num`, `reg_data`) and data-memory writes (`wr`, `addr`, `wr_data`). Events are queued in an internal FIFO and drained to a debug host over a valid/ready handshake. On `Halt` it stops capturing, drains, and then signals `done`, so testbenches and host tooling can compare a complete architectural trace against a golden model.

## Interface
- `DEPTH`, 16: FIFO entries; power of two, ≥4.
- `DATA_W`, 32: data width of captured values.
- `clk` in 1: single clock; everything is sampled on the rising edge.
- `reset` in 1: synchronous, active-low; sampled on the `clk` rising edge.
- `reg_write_sig` in 1: register-file write strobe from the core.
- `reg_num` in 5: destination register.
- `reg_data` in DATA_W: writeback value.
- `wr` in 1: data-memory write strobe.
- `addr` in 9: data-memory address.
- `wr_data` in DATA_W: store data.
- `Halt` in 1: core halt indication (level).
- `out_valid` out 1: a trace record is available at the head.
- `out_ready` in 1: host accepts the record.
- `out_kind` out 1: 0 = register writeback, 1 = memory write.
- `out_tag` out 9: `reg_num` zero-extended, or `addr`.
- `out_data` out DATA_W: `reg_data` or `wr_data`.
- `level` out $clog2(DEPTH)+1: current occupancy, 0..DEPTH.
- `overflow` out 1: sticky; set when any event is dropped.
- `drop_count` out 16: number of dropped events, saturating at 0xFFFF.
- `done` out 1: halted and fully drained.

## Operation
- **Record format:** {kind, tag[8:0], data}. The FIFO is first-word-fall-through. `out_kind`, `out_tag` and `out_data` show the head entry when `out_valid` = 1, and are driven to 0 when `out_valid` = 0.
- **Register capture:** enqueue a record when `reg_write_sig` = 1 and `reg_num` ≠ 0. Writes to x0 are silently filtered; they are neither recorded nor counted as drops.
- **Memory capture:** enqueue a record when `wr` = 1.
- **Simultaneous events:** when a register event and a memory event occur in the same cycle, the register record is enqueued first and the memory record second. This needs two free slots.
  - With exactly one free slot, the register record is kept and the memory record is dropped.
  - With zero free slots, both are dropped. `drop_count` increases by the number of events dropped (1 or 2).
- **Free slots for push:** computed as DEPTH − `level` + (pop this cycle ? 1 : 0). A pop frees its slot in the same cycle.
- **Pop:** occurs when `out_valid` && `out_ready`. Push and pop in the same cycle are both performed. `level` changes by (pushes − pops).
- **Pointers:** read and write pointers are $clog2(DEPTH) bits wide and wrap modulo DEPTH. Full and empty are derived from `level`, not from pointer equality.
- **State machine:** RUN → DRAIN → DONE.
  - **RUN:** capture enabled. If `Halt` = 1, events in that same cycle are still captured, and the next state is DRAIN.
  - **DRAIN:** capture disabled; all strobes are ignored and never count as drops. When `level` will be 0 at the end of the cycle, go to DONE.
  - **DONE:** `done` = 1; capture disabled; stays in DONE until reset. Deasserting `Halt` has no effect.
- **Saturation:** `drop_count` stops at 0xFFFF. `overflow` remains set.

## Timing
- **Reset** (`reset` = 0 at a clock edge): state RUN, `level` 0, pointers 0, `out_valid` 0, `out_kind`/`out_tag`/`out_data` 0, `overflow` 0, `drop_count` 0, `done` 0. FIFO storage contents are don't-care.
- **Reset mid-operation:** all queued records are discarded. Events presented in the reset cycle are not captured.
- **Capture latency:** an event sampled at edge N appears at the output after edge N, i.e. `out_valid` is high in cycle N+1 when the FIFO was empty.
- **Dual event into an empty FIFO:** the register record is at the head in cycle N+1. The memory record becomes the head in the cycle after the register record is popped.
- **Handshake rules:**
  - `out_valid`, once high, stays high and the head stays stable until popped.
  - `out_ready` may be held high continuously, giving one pop per cycle.
  - `out_valid` does not depend combinationally on `out_ready`.
- **Halt with an empty FIFO:** `Halt` sampled at edge N with nothing queued or captured gives `done` = 1 after edge N+1.
- **Final pop:** when the last record is popped at edge M in DRAIN, `done` = 1 after edge M.

## Test plan
- **Basic capture:** reg write x5 = 0x12345678, then a store addr 0x040 data 0xDEADBEEF, `out_ready` = 1 → records {0, 0x005, 0x12345678} then {1, 0x040, 0xDEADBEEF}, each appearing one cycle after its event; `level` returns to 0.
- **x0 filter:** `reg_write_sig` = 1, `reg_num` = 0 for 10 cycles → `level` stays 0, `out_valid` stays 0, `drop_count` stays 0.
- **Overflow:** `out_ready` = 0 and DEPTH+3 reg writes → `level` = 16, `overflow` = 1, `drop_count` = 3. Then draining returns the first 16 records in order.
- **Dual event at level 15:** reg x1 = 1 and store addr 0x004 = 2 in the same cycle, no pop → reg record kept, `level` = 16, `drop_count` +1. Repeat the same dual event with `out_ready` = 1 at level 15 → both records stored, `level` stays 16.
- **Halt drain:** queue 4 records, assert `Halt` together with a fifth store, then keep the strobes toggling → exactly 5 records drain, `done` rises in the cycle after the fifth pop, and no records are added after `Halt`.
- **Reset mid-drain:** hold `reset` = 0 for one cycle with 8 records queued → `level` 0, `out_valid` 0, `done` 0, `overflow` 0. A new reg write x2 = 7 is then captured normally.
